// File: rtl/serdes_rx_deframer.sv
// ----------------------------------------------------------------------------
// Module  : serdes_rx_deframer
// Brief   : Serial receive deframer with sync-byte word lock, frame/parity
//           checking and a saturating error counter.
//           Optional even parity enabled by defining SERDES_RX_PARITY_EN.
// Rev     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module serdes_rx_deframer #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hD5,
  parameter int unsigned LOSS_THRESH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ser_in,
  input  logic       bit_en,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       locked,
  output logic       frame_err,
  output logic       parity_err,
  output logic [7:0] err_cnt
);

  localparam logic [3:0] c_LOSS_THRESH = 4'(LOSS_THRESH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAR  = 2'd2,
    S_STOP = 2'd3
  } state_t;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [7:0]  shift_q;
  logic [3:0]  bad_cnt_q;
  logic [7:0]  data_out_q;
  logic        data_valid_q;
  logic        locked_q;
  logic        frame_err_q;
  logic [7:0]  err_cnt_q;

  logic [7:0]  err_cnt_d;
  logic [3:0]  bad_cnt_d;
  logic        w_par_fail;
  logic        w_frame_bad;

`ifdef SERDES_RX_PARITY_EN
  logic        par_q;
  logic        parity_err_q;
  assign w_par_fail = ^{shift_q, par_q};
  assign parity_err = parity_err_q;
`else
  assign w_par_fail = 1'b0;
  assign parity_err = 1'b0;
`endif

  // A missing stop bit outranks any parity result.
  assign w_frame_bad = ~ser_in | w_par_fail;
  assign err_cnt_d   = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
  assign bad_cnt_d   = bad_cnt_q + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      shift_q      <= 8'd0;
      bad_cnt_q    <= 4'd0;
      data_out_q   <= 8'd0;
      data_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      frame_err_q  <= 1'b0;
      err_cnt_q    <= 8'd0;
`ifdef SERDES_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef SERDES_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (bit_en) begin
        case (state_q)
          S_IDLE: begin
            if (!ser_in) begin
              state_q <= S_DATA;
              cnt_q   <= 3'd0;
            end
          end
          S_DATA: begin
            shift_q[cnt_q] <= ser_in;
            cnt_q          <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
`ifdef SERDES_RX_PARITY_EN
              state_q <= S_PAR;
`else
              state_q <= S_STOP;
`endif
            end
          end
          S_PAR: begin
`ifdef SERDES_RX_PARITY_EN
            par_q <= ser_in;
`endif
            state_q <= S_STOP;
          end
          S_STOP: begin
            state_q <= S_IDLE;
            if (w_frame_bad) begin
              frame_err_q <= ~ser_in;
`ifdef SERDES_RX_PARITY_EN
              parity_err_q <= ser_in;
`endif
              err_cnt_q <= err_cnt_d;
              if (bad_cnt_d == c_LOSS_THRESH) begin
                locked_q  <= 1'b0;
                bad_cnt_q <= 4'd0;
              end else begin
                bad_cnt_q <= bad_cnt_d;
              end
            end else begin
              bad_cnt_q <= 4'd0;
              if (!locked_q) begin
                if (shift_q == SYNC_BYTE) locked_q <= 1'b1;
              end else if (shift_q != SYNC_BYTE) begin
                data_out_q   <= shift_q;
                data_valid_q <= 1'b1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign locked     = locked_q;
  assign frame_err  = frame_err_q;
  assign err_cnt    = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_serdes_rx_deframer.sv
// ----------------------------------------------------------------------------
// Module  : tb_serdes_rx_deframer
// Brief   : Directed self-checking bench for serdes_rx_deframer.
// Rev     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_serdes_rx_deframer;

  logic       clk;
  logic       rst_n;
  logic       ser_in;
  logic       bit_en;
  logic [7:0] data_out;
  logic       data_valid;
  logic       locked;
  logic       frame_err;
  logic       parity_err;
  logic [7:0] err_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int dv_count = 0;
  int fe_count = 0;
  int pe_count = 0;

  logic seen_dv, seen_fe, seen_pe;

  serdes_rx_deframer #(
    .SYNC_BYTE  (8'hD5),
    .LOSS_THRESH(4)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ser_in    (ser_in),
    .bit_en    (bit_en),
    .data_out  (data_out),
    .data_valid(data_valid),
    .locked    (locked),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (data_valid) dv_count++;
    if (frame_err)  fe_count++;
    if (parity_err) pe_count++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic gap);
    if (gap) begin
      @(negedge clk);
      bit_en = 1'b0;
      ser_in = 1'b1;
    end
    @(negedge clk);
    ser_in = b;
    bit_en = 1'b1;
  endtask

  // Ends on the negedge right after the stop-bit edge, capturing the pulses.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input logic par_flip, input logic gap);
    send_bit(1'b0, gap);
    for (int i = 0; i < 8; i++) send_bit(b[i], gap);
`ifdef SERDES_RX_PARITY_EN
    send_bit(^b ^ par_flip, gap);
`endif
    send_bit(stop, gap);
    @(negedge clk);
    bit_en  = 1'b0;
    ser_in  = 1'b1;
    seen_dv = data_valid;
    seen_fe = frame_err;
    seen_pe = parity_err;
  endtask

  initial begin
    int base_dv;
    int base_fe;
    rst_n  = 1'b0;
    ser_in = 1'b1;
    bit_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check_eq("rst_data_out",   32'(data_out),   32'h00);
    check_eq("rst_data_valid", 32'(data_valid), 32'h0);
    check_eq("rst_locked",     32'(locked),     32'h0);
    check_eq("rst_frame_err",  32'(frame_err),  32'h0);
    check_eq("rst_parity_err", 32'(parity_err), 32'h0);
    check_eq("rst_err_cnt",    32'(err_cnt),    32'h00);

    for (int i = 0; i < 20; i++) send_bit(1'b1, 1'b0);
    @(negedge clk);
    bit_en = 1'b0;
    check_eq("idle_locked",  32'(locked),  32'h0);
    check_eq("idle_err_cnt", 32'(err_cnt), 32'h0);
    check_eq("idle_dv_cnt",  32'(dv_count), 32'h0);

    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    check_eq("prelock_dv",     32'(seen_dv), 32'h0);
    check_eq("prelock_locked", 32'(locked),  32'h0);

    send_frame(8'hD5, 1'b1, 1'b0, 1'b1);
    check_eq("sync_locked", 32'(locked),  32'h1);
    check_eq("sync_dv",     32'(seen_dv), 32'h0);

    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    check_eq("data3c_dv",   32'(seen_dv),  32'h1);
    check_eq("data3c_byte", 32'(data_out), 32'h3C);
    @(negedge clk);
    check_eq("data3c_pulse_width", 32'(data_valid), 32'h0);
    check_eq("data3c_dv_cnt",      32'(dv_count),   32'h1);

    send_frame(8'hD5, 1'b1, 1'b0, 1'b1);
    check_eq("fill_dv", 32'(seen_dv), 32'h0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    check_eq("data81_byte",   32'(data_out), 32'h81);
    check_eq("data81_dv_cnt", 32'(dv_count), 32'h2);

    base_fe = fe_count;
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h12, 1'b0, 1'b0, 1'b0);
      check_eq("bad_fe_pulse", 32'(seen_fe), 32'h1);
      check_eq("bad_no_dv",    32'(seen_dv), 32'h0);
      if (i == 2) check_eq("bad3_still_locked", 32'(locked), 32'h1);
    end
    check_eq("loss_unlocked", 32'(locked),           32'h0);
    check_eq("loss_err_cnt",  32'(err_cnt),          32'h04);
    check_eq("loss_fe_cnt",   32'(fe_count - base_fe), 32'h4);
    check_eq("loss_data_held", 32'(data_out),        32'h81);

    send_frame(8'hD5, 1'b1, 1'b0, 1'b0);
    check_eq("relock", 32'(locked), 32'h1);
    for (int i = 0; i < 3; i++) send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(8'h42, 1'b1, 1'b0, 1'b0);
    check_eq("recover_locked", 32'(locked),   32'h1);
    check_eq("recover_byte",   32'(data_out), 32'h42);
    check_eq("recover_errcnt", 32'(err_cnt),  32'h07);
    for (int i = 0; i < 3; i++) send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    check_eq("bad_cnt_cleared_locked", 32'(locked),  32'h1);
    check_eq("bad_cnt_cleared_errcnt", 32'(err_cnt), 32'h0A);

`ifdef SERDES_RX_PARITY_EN
    send_frame(8'hA0, 1'b1, 1'b1, 1'b0);
    check_eq("par_pe_pulse", 32'(seen_pe), 32'h1);
    check_eq("par_no_fe",    32'(seen_fe), 32'h0);
    check_eq("par_no_dv",    32'(seen_dv), 32'h0);
    check_eq("par_errcnt",   32'(err_cnt), 32'h0B);
    send_frame(8'hA0, 1'b1, 1'b0, 1'b0);
    check_eq("par_ok_dv",   32'(seen_dv),  32'h1);
    check_eq("par_ok_byte", 32'(data_out), 32'hA0);
`else
    check_eq("nopar_pe_cnt", 32'(pe_count), 32'h0);
`endif

    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    @(negedge clk);
    bit_en = 1'b0;
    rst_n  = 1'b0;
    base_dv = dv_count;
    base_fe = fe_count;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("midrst_data_out", 32'(data_out), 32'h00);
    check_eq("midrst_locked",   32'(locked),   32'h0);
    check_eq("midrst_err_cnt",  32'(err_cnt),  32'h00);
    check_eq("midrst_pulses",
             32'((dv_count - base_dv) + (fe_count - base_fe) + 32'(data_valid) +
                 32'(frame_err) + 32'(parity_err)), 32'h0);

    send_frame(8'hD5, 1'b1, 1'b0, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0, 1'b1);
    check_eq("postrst_locked", 32'(locked),   32'h1);
    check_eq("postrst_dv",     32'(seen_dv),  32'h1);
    check_eq("postrst_byte",   32'(data_out), 32'h55);

    for (int i = 0; i < 300; i++) begin
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
      if (i == 9)   check_eq("sat_errcnt_10",  32'(err_cnt), 32'h0A);
      if (i == 253) check_eq("sat_errcnt_254", 32'(err_cnt), 32'hFE);
    end
    check_eq("sat_errcnt_ff", 32'(err_cnt), 32'hFF);
    check_eq("sat_unlocked",  32'(locked),  32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
